// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned BANK_WIDTH_DEF = 5;
    localparam int unsigned WIDTH_DEF      = 64;
    localparam int unsigned DEPTH_DEF      = 4;
    localparam int unsigned STARVE_MAX_DEF = 8;
    localparam int unsigned REG_ZERO       = 0;

    typedef struct packed {
        logic [BANK_WIDTH_DEF-1:0] rd;
        logic [WIDTH_DEF-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of pipeline writeback, long-latency completion, issue and register-file port signals.
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = BANK_WIDTH_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF
);
    logic                     wb_we;
    logic [BANK_WIDTH-1:0]    wb_rd;
    logic [WIDTH-1:0]         wb_data;
    logic                     wb_stall;
    logic                     ll_valid;
    logic [BANK_WIDTH-1:0]    ll_rd;
    logic [WIDTH-1:0]         ll_data;
    logic                     ll_ready;
    logic                     issue_valid;
    logic [BANK_WIDTH-1:0]    issue_rd;
    logic [2**BANK_WIDTH-1:0] busy;
    logic                     we3;
    logic [BANK_WIDTH-1:0]    wa3;
    logic [WIDTH-1:0]         wd3;
    logic                     err;

    // Arbiter side
    modport slave (
        input  wb_we, wb_rd, wb_data, ll_valid, ll_rd, ll_data, issue_valid, issue_rd,
        output wb_stall, ll_ready, busy, we3, wa3, wd3, err
    );

    // Producer / register-file side
    modport master (
        output wb_we, wb_rd, wb_data, ll_valid, ll_rd, ll_data, issue_valid, issue_rd,
        input  wb_stall, ll_ready, busy, we3, wa3, wd3, err
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results; pointers wrap mod DEPTH (power of two).
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter type         T     = wb_entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  T     din_i,
    input  logic pop_i,
    output T     dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Sole register-file write port: pipeline writeback has priority over buffered long-latency
// results, with a starvation stall and a per-register pending-write scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = BANK_WIDTH_DEF,
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    wb_arbiter_if.slave  bus
);
    localparam int unsigned NREG = 2**BANK_WIDTH;
    localparam int unsigned SW   = $clog2(STARVE_MAX + 1);
    localparam logic [BANK_WIDTH-1:0] RZ = BANK_WIDTH'(REG_ZERO);

    typedef struct packed {
        logic [BANK_WIDTH-1:0] rd;
        logic [WIDTH-1:0]      data;
    } entry_t;

    entry_t                head, ll_entry;
    logic                  full, empty, push, pop;
    logic                  pipe_req, grant_pipe, stall;
    logic                  we;
    logic [BANK_WIDTH-1:0] wa;
    logic [WIDTH-1:0]      wd;
    logic [SW-1:0]         starve_q, starve_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  err_q, err_d;

    assign ll_entry = '{rd: bus.ll_rd, data: bus.ll_data};

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .din_i   (ll_entry),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        stall      = (starve_q == SW'(STARVE_MAX));
        pipe_req   = bus.wb_we && (bus.wb_rd != RZ);
        grant_pipe = pipe_req && !stall;
        pop        = !grant_pipe && !empty;
        push       = bus.ll_valid && !full;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        if (grant_pipe) begin
            we = 1'b1;
            wa = bus.wb_rd;
            wd = bus.wb_data;
        end else if (pop) begin
            // An x0 entry still consumes its slot but never writes.
            we = (head.rd != RZ);
            wa = head.rd;
            wd = head.data;
        end
    end

    always_comb begin
        starve_d = (!empty && !pop) ? starve_q + SW'(1) : '0;

        busy_d = busy_q;
        if (pop && head.rd != RZ) busy_d[head.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != RZ) busy_d[bus.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        err_d = err_q;
        if (bus.issue_valid && bus.issue_rd != RZ && busy_q[bus.issue_rd]
            && !(pop && head.rd == bus.issue_rd)) err_d = 1'b1;
        if (pipe_req && busy_q[bus.wb_rd]) err_d = 1'b1;
        if (push && !busy_q[bus.ll_rd]) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
            busy_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    // Write port is held quiet for the whole reset assertion, not just after the edge.
    assign bus.we3      = we && reset_n;
    assign bus.wa3      = reset_n ? wa : '0;
    assign bus.wd3      = reset_n ? wd : '0;
    assign bus.wb_stall = stall;
    assign bus.ll_ready = !full;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sole writer of the integer register file's write port (we3/wa3/wd3).
- Merges two result sources onto that port:
  - the in-order pipeline writeback, which has fixed priority;
  - a long-latency completion port (mul/div, loads), buffered in a small FIFO.
- Keeps a per-register busy scoreboard so issue logic can stall on pending long-latency destinations.
- Sits between execute/memory completion and the register file.

Parameters:
- BANK_WIDTH, 5, register address width (32 registers).
- WIDTH, 64, data width.
- DEPTH, 4, long-latency FIFO entries (power of two, >=2).
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may lose arbitration before the pipeline is stalled.

Ports:
- clk  in  1  clock, all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_we  in  1  pipeline write request.
- wb_rd  in  BANK_WIDTH  pipeline destination.
- wb_data  in  WIDTH  pipeline result.
- wb_stall  out  1  pipeline must hold wb_* this cycle; its write is not taken.
- ll_valid  in  1  long-latency result valid.
- ll_rd  in  BANK_WIDTH  long-latency destination.
- ll_data  in  WIDTH  long-latency result.
- ll_ready  out  1  FIFO can accept (= not full).
- issue_valid  in  1  a long-latency op is issued this cycle.
- issue_rd  in  BANK_WIDTH  its destination.
- busy  out  2**BANK_WIDTH  per-register pending-write bits.
- we3  out  1  register file write enable.
- wa3  out  BANK_WIDTH  register file write address.
- wd3  out  WIDTH  register file write data.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset_n low, async):
  - FIFO emptied; busy = 0; starve counter = 0; err = 0; wb_stall = 0; ll_ready = 1.
  - we3 forced 0 while reset_n low; wa3/wd3 = 0.
  - Applies mid-operation: queued results are discarded.
- Arbitration is combinational, evaluated each cycle:
  - pipe_req = wb_we && wb_rd != 0; a write to x0 counts as no request.
  - If wb_stall = 0 and pipe_req: we3 = 1, wa3 = wb_rd, wd3 = wb_data. The FIFO does not pop.
  - Else if the FIFO is non-empty: pop the head; we3 = 1, wa3/wd3 = head fields.
  - Else: we3 = 0, wa3 = 0, wd3 = 0.
- FIFO:
  - Push when ll_valid && ll_ready.
  - ll_ready = !full, taken from registered count. A full FIFO refuses pushes even in a cycle when it pops.
  - No bypass: a result pushed into an empty FIFO is first written the next cycle, so minimum ll latency to we3 is 1 cycle.
  - Push and pop in the same cycle keep the count unchanged; pointers wrap mod DEPTH.
  - An ll push with ll_rd = 0 is accepted and later popped with we3 = 0 (slot consumed, no write).
- Starvation:
  - starve_cnt increments each cycle the FIFO is non-empty and does not pop; it clears on any pop or when the FIFO is empty.
  - wb_stall = (starve_cnt == STARVE_MAX), derived from registered state only.
  - While wb_stall = 1 the FIFO head wins. The pipeline write is taken the following cycle, when wb_stall has returned to 0.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets busy[issue_rd] at the next edge.
  - A FIFO pop with rd != 0 clears busy[rd].
  - Set and clear of the same bit in one cycle: set wins.
  - busy[0] is always 0.
- err is set (sticky until reset) on any of:
  - issue to an already-busy rd with no same-cycle clear;
  - a pipeline write (pipe_req) to a busy rd;
  - an ll push whose rd is not busy.
- err has no other functional effect.

Decomposition:
- Shared package wb_pkg holds:
  - typedef wb_entry_t {rd, data};
  - constants for default DEPTH/STARVE_MAX;
  - REG_ZERO = 0.
- One sub-module, wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty and async active-low reset.
- Scoreboard and arbitration stay inline.

Test Plan:
- Pipeline only: wb_we = 1, wb_rd = 5, wb_data = 0xAB each cycle -> we3 = 1, wa3 = 5, wd3 = 0xAB the same cycle; busy stays 0.
- Long-latency path:
  - issue_rd = 7 -> busy[7] = 1 next cycle.
  - ll push rd = 7, data = 0x300 with wb_we = 0 -> next cycle we3 = 1, wa3 = 7, wd3 = 0x300; busy[7] = 0 one cycle after that.
- Collision: pipeline rd = 3 and FIFO head rd = 9 in the same cycle -> rd 3 written; rd 9 written the first cycle wb_we = 0.
- Starvation:
  - FIFO holds 1 entry; wb_we = 1 continuously -> wb_stall = 1 on the 9th cycle (STARVE_MAX = 8); the FIFO entry is written that cycle.
  - wb_stall = 0 the next cycle and the held pipeline write lands.
- Full/wrap:
  - 4 pushes with wb_we = 1 and no pops -> ll_ready = 0; a 5th ll_valid is not accepted.
  - Drain 4 entries, push 6 more -> all 6 written in order, confirming pointer wrap.
- Reset mid-operation: 3 queued entries and busy = 0x88, assert reset_n = 0 -> we3 = 0, busy = 0, ll_ready = 1 immediately; no queued write appears after release.
- Errors: issue to rd = 4 twice -> err = 1 and stays 1; pipeline write to a busy rd -> err = 1.
